branch_ctrl: RTL and testbench

//  Sequences branch/jump resolution in the RV32 core. Accepts a branch op from decode and drives
//  the ALU compare request. Evaluates the ALU neg/zero flags under the branch_type encoding,

---
 rtl/branch_ctrl_if.sv | 43 ++++
 rtl/branch_ctrl.sv | 148 ++++++++++++++
 tb/tb_branch_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - decode/ALU/front-end handshake bundle for branch_ctrl
//
// Purpose: groups every non-clock signal of the branch controller.
// Ports (signals):
//   br_valid, branch_type[2:0], target_pc[31:0]  decode -> controller
//   br_ready                                     controller -> decode
//   alu_req                                      controller -> ALU
//   alu_done, ALU_neg_flag, ALU_zero_flag        ALU -> controller
//   resolve_valid, resolve_taken                 resolution report
//   pc_redirect, redirect_pc[31:0], flush, stall front-end control
//   taken_cnt[CNT_W-1:0]                         perf counter
// Modports: master = surrounding core side, slave = branch_ctrl.
interface branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       branch_type;
  logic [31:0]      target_pc;
  logic             alu_req;
  logic             alu_done;
  logic             ALU_neg_flag;
  logic             ALU_zero_flag;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             pc_redirect;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             stall;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output br_valid, branch_type, target_pc, alu_done, ALU_neg_flag, ALU_zero_flag,
    input  br_ready, alu_req, resolve_valid, resolve_taken, pc_redirect, redirect_pc,
           flush, stall, taken_cnt
  );

  modport slave (
    input  br_valid, branch_type, target_pc, alu_done, ALU_neg_flag, ALU_zero_flag,
    output br_ready, alu_req, resolve_valid, resolve_taken, pc_redirect, redirect_pc,
           flush, stall, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - RV32 branch/jump resolution sequencer
//
// Purpose: accepts a branch op, requests an ALU compare, evaluates the
// neg/zero flags per branch_type, then issues a PC redirect and a front-end
// flush of FLUSH_CYCLES cycles. Stalls issue while busy; counts taken branches.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous reset, active-high
//   bus  slave modport of branch_ctrl_if (all handshake/bus signals)
// Parameters:
//   FLUSH_CYCLES  cycles flush is high per taken branch (>=1), RSLV included
//   CNT_W         taken-branch counter width (must match the interface)
module branch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic           clk,
  input logic           rst,
  branch_ctrl_if.slave  bus
);

  localparam int CTR_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    RSLV  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [2:0] BT_EQ   = 3'd1;
  localparam logic [2:0] BT_NE   = 3'd2;
  localparam logic [2:0] BT_LT   = 3'd3;
  localparam logic [2:0] BT_GT   = 3'd4;
  localparam logic [2:0] BT_JUMP = 3'd5;

  state_t             state;
  state_t             state_nxt;
  logic               taken;
  logic [2:0]         br_type;
  logic [31:0]        redirect_pc;
  logic [CTR_W-1:0]   ctr;
  logic [CNT_W-1:0]   taken_cnt;
  logic               accept;
  logic               cmp_taken;

  assign accept = bus.br_valid && (state == IDLE);

  // Condition evaluation uses the latched type and the live flags; only
  // consumed in CMP when alu_done is high.
  always_comb begin
    cmp_taken = 1'b0;
    case (br_type)
      BT_EQ:   cmp_taken = bus.ALU_zero_flag;
      BT_NE:   cmp_taken = !bus.ALU_zero_flag;
      BT_LT:   cmp_taken = bus.ALU_neg_flag;
      BT_GT:   cmp_taken = !bus.ALU_neg_flag && !bus.ALU_zero_flag;
      default: cmp_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.branch_type >= BT_EQ && bus.branch_type <= BT_GT) begin
            state_nxt = CMP;
          end else begin
            state_nxt = RSLV;
          end
        end
      end
      CMP: begin
        if (bus.alu_done) begin
          state_nxt = RSLV;
        end
      end
      RSLV: begin
        if (taken && FLUSH_CYCLES > 1) begin
          state_nxt = FLUSH;
        end else begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        // ctr <= 1 also catches an unexpected zero so the FSM cannot stick.
        if (ctr <= CTR_W'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic (Moore: outputs depend only on state and latched data)
  always_comb begin
    bus.br_ready      = (state == IDLE);
    bus.alu_req       = (state == CMP);
    bus.resolve_valid = (state == RSLV);
    bus.resolve_taken = (state == RSLV) && taken;
    bus.pc_redirect   = (state == RSLV) && taken;
    bus.flush         = ((state == RSLV) && taken) || (state == FLUSH);
    bus.stall         = (state != IDLE);
  end

  assign bus.redirect_pc = redirect_pc;
  assign bus.taken_cnt   = taken_cnt;

  // Datapath: latched op, outcome, flush counter and perf counter
  always_ff @(posedge clk) begin
    if (rst) begin
      taken       <= 1'b0;
      br_type     <= 3'd0;
      redirect_pc <= 32'd0;
      ctr         <= '0;
      taken_cnt   <= '0;
    end else begin
      if (accept) begin
        br_type     <= bus.branch_type;
        redirect_pc <= bus.target_pc & 32'hFFFF_FFFE;
        // Jumps are taken without a compare; types 0/6/7 resolve not-taken.
        taken       <= (bus.branch_type == BT_JUMP);
      end
      if (state == CMP && bus.alu_done) begin
        taken <= cmp_taken;
      end
      if (state == RSLV && taken) begin
        taken_cnt <= taken_cnt + 1'b1;
        ctr       <= CTR_W'(FLUSH_CYCLES - 1);
      end
      if (state == FLUSH) begin
        ctr <= ctr - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl
//
// Purpose: drives directed branch scenarios into a default instance
// (FLUSH_CYCLES=2, CNT_W=16) and a small instance (FLUSH_CYCLES=1, CNT_W=4)
// used for the single-cycle-flush and counter-wrap cases.
// Output vector order used in checks:
//   {br_ready, alu_req, resolve_valid, resolve_taken, pc_redirect, flush, stall}
module tb_branch_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  branch_ctrl_if #(.CNT_W(16)) bus  ();
  branch_ctrl_if #(.CNT_W(4))  bus2 ();

  branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  branch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs1();
    return {bus.br_ready, bus.alu_req, bus.resolve_valid, bus.resolve_taken,
            bus.pc_redirect, bus.flush, bus.stall};
  endfunction

  function automatic logic [6:0] outs2();
    return {bus2.br_ready, bus2.alu_req, bus2.resolve_valid, bus2.resolve_taken,
            bus2.pc_redirect, bus2.flush, bus2.stall};
  endfunction

  // Advance one cycle; sample/drive 1 ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (outs1() !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_outs got %b exp %b", outs1(), 7'b1000000);
    end
    n_tests++;
    if (bus.taken_cnt !== 16'd0 || bus.redirect_pc !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs got cnt=%h pc=%h exp 0/0", bus.taken_cnt, bus.redirect_pc);
    end
    n_tests++;
    if (outs2() !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_outs2 got %b exp %b", outs2(), 7'b1000000);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_beq();
    bus.br_valid = 1'b1; bus.branch_type = 3'd1; bus.target_pc = 32'h100;
    step();                                             // c1
    bus.br_valid = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0100001) begin
      n_fail++; $display("FAIL beq_c1 got %b exp %b", outs1(), 7'b0100001);
    end
    bus.alu_done = 1'b1; bus.ALU_zero_flag = 1'b1; bus.ALU_neg_flag = 1'b0;
    step();                                             // c2
    bus.alu_done = 1'b0; bus.ALU_zero_flag = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0011111 || bus.redirect_pc !== 32'h100) begin
      n_fail++; $display("FAIL beq_c2 got %b pc=%h exp %b pc=00000100", outs1(), bus.redirect_pc, 7'b0011111);
    end
    step();                                             // c3
    n_tests++;
    if (outs1() !== 7'b0000011) begin
      n_fail++; $display("FAIL beq_c3 got %b exp %b", outs1(), 7'b0000011);
    end
    step();                                             // c4
    n_tests++;
    if (outs1() !== 7'b1000000 || bus.taken_cnt !== 16'd1) begin
      n_fail++; $display("FAIL beq_c4 got %b cnt=%0d exp %b cnt=1", outs1(), bus.taken_cnt, 7'b1000000);
    end
  endtask

  task automatic test_bne();
    bus.br_valid = 1'b1; bus.branch_type = 3'd2; bus.target_pc = 32'h180;
    step();                                             // c1
    bus.br_valid = 1'b0;
    bus.alu_done = 1'b1; bus.ALU_zero_flag = 1'b1;
    step();                                             // c2
    bus.alu_done = 1'b0; bus.ALU_zero_flag = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0010001) begin
      n_fail++; $display("FAIL bne_c2 got %b exp %b", outs1(), 7'b0010001);
    end
    step();                                             // c3
    n_tests++;
    if (outs1() !== 7'b1000000 || bus.taken_cnt !== 16'd1) begin
      n_fail++; $display("FAIL bne_c3 got %b cnt=%0d exp %b cnt=1", outs1(), bus.taken_cnt, 7'b1000000);
    end
  endtask

  task automatic test_gt_slow_alu();
    bus.br_valid = 1'b1; bus.branch_type = 3'd4; bus.target_pc = 32'h3FF;
    step();                                             // c1
    bus.br_valid = 1'b0;
    // Flags toggle while alu_done is low; they must not be sampled.
    bus.ALU_neg_flag = 1'b1; bus.ALU_zero_flag = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      n_tests++;
      if (outs1() !== 7'b0100001) begin
        n_fail++; $display("FAIL gt_wait_c%0d got %b exp %b", i, outs1(), 7'b0100001);
      end
      step();
    end
    // c4
    bus.alu_done = 1'b1; bus.ALU_neg_flag = 1'b0; bus.ALU_zero_flag = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0100001) begin
      n_fail++; $display("FAIL gt_c4 got %b exp %b", outs1(), 7'b0100001);
    end
    step();                                             // c5
    bus.alu_done = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0011111 || bus.redirect_pc !== 32'h3FE) begin
      n_fail++; $display("FAIL gt_c5 got %b pc=%h exp %b pc=000003fe", outs1(), bus.redirect_pc, 7'b0011111);
    end
    step();                                             // c6
    n_tests++;
    if (outs1() !== 7'b0000011) begin
      n_fail++; $display("FAIL gt_c6 got %b exp %b", outs1(), 7'b0000011);
    end
    step();                                             // c7
    n_tests++;
    if (outs1() !== 7'b1000000 || bus.taken_cnt !== 16'd2) begin
      n_fail++; $display("FAIL gt_c7 got %b cnt=%0d exp %b cnt=2", outs1(), bus.taken_cnt, 7'b1000000);
    end
  endtask

  task automatic test_lt();
    bus.br_valid = 1'b1; bus.branch_type = 3'd3; bus.target_pc = 32'h440;
    step();
    bus.br_valid = 1'b0;
    bus.alu_done = 1'b1; bus.ALU_neg_flag = 1'b1; bus.ALU_zero_flag = 1'b0;
    step();
    bus.alu_done = 1'b0; bus.ALU_neg_flag = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0011111 || bus.redirect_pc !== 32'h440) begin
      n_fail++; $display("FAIL lt_rslv got %b pc=%h exp %b pc=00000440", outs1(), bus.redirect_pc, 7'b0011111);
    end
    step();
    step();
    n_tests++;
    if (bus.taken_cnt !== 16'd3) begin
      n_fail++; $display("FAIL lt_cnt got %0d exp 3", bus.taken_cnt);
    end
  endtask

  task automatic test_jump();
    // Flags/alu_done asserted outside CMP must be ignored.
    bus.alu_done = 1'b1; bus.ALU_zero_flag = 1'b0;
    bus.br_valid = 1'b1; bus.branch_type = 3'd5; bus.target_pc = 32'h203;
    step();                                             // c1
    bus.br_valid = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0011111 || bus.redirect_pc !== 32'h202) begin
      n_fail++; $display("FAIL jump_c1 got %b pc=%h exp %b pc=00000202", outs1(), bus.redirect_pc, 7'b0011111);
    end
    step();                                             // c2
    n_tests++;
    if (outs1() !== 7'b0000011) begin
      n_fail++; $display("FAIL jump_c2 got %b exp %b", outs1(), 7'b0000011);
    end
    step();                                             // c3
    bus.alu_done = 1'b0;
    n_tests++;
    if (outs1() !== 7'b1000000 || bus.taken_cnt !== 16'd4) begin
      n_fail++; $display("FAIL jump_c3 got %b cnt=%0d exp %b cnt=4", outs1(), bus.taken_cnt, 7'b1000000);
    end
  endtask

  task automatic test_none_type();
    bus.br_valid = 1'b1; bus.branch_type = 3'd6; bus.target_pc = 32'h555;
    step();
    bus.br_valid = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0010001 || bus.redirect_pc !== 32'h554) begin
      n_fail++; $display("FAIL none_rslv got %b pc=%h exp %b pc=00000554", outs1(), bus.redirect_pc, 7'b0010001);
    end
    step();
    n_tests++;
    if (outs1() !== 7'b1000000 || bus.taken_cnt !== 16'd4) begin
      n_fail++; $display("FAIL none_idle got %b cnt=%0d exp %b cnt=4", outs1(), bus.taken_cnt, 7'b1000000);
    end
  endtask

  task automatic test_reset_in_cmp();
    bus.br_valid = 1'b1; bus.branch_type = 3'd1; bus.target_pc = 32'h700;
    step();                                             // c1, CMP
    bus.br_valid = 1'b0;
    n_tests++;
    if (outs1() !== 7'b0100001) begin
      n_fail++; $display("FAIL rstcmp_c1 got %b exp %b", outs1(), 7'b0100001);
    end
    rst = 1'b1; bus.alu_done = 1'b1; bus.ALU_zero_flag = 1'b1;
    step();                                             // c2
    rst = 1'b0; bus.alu_done = 1'b0; bus.ALU_zero_flag = 1'b0;
    n_tests++;
    if (outs1() !== 7'b1000000 || bus.taken_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rstcmp_c2 got %b cnt=%0d exp %b cnt=0", outs1(), bus.taken_cnt, 7'b1000000);
    end
    step();                                             // c3
    n_tests++;
    if (outs1() !== 7'b1000000) begin
      n_fail++; $display("FAIL rstcmp_c3 got %b exp %b", outs1(), 7'b1000000);
    end
  endtask

  task automatic test_wrap_flush1();
    for (int i = 0; i < 15; i++) begin
      bus2.br_valid = 1'b1; bus2.branch_type = 3'd5; bus2.target_pc = 32'h1000 + i;
      step();
      bus2.br_valid = 1'b0;
      step();
    end
    n_tests++;
    if (bus2.taken_cnt !== 4'hF) begin
      n_fail++; $display("FAIL wrap_pre got %h exp f", bus2.taken_cnt);
    end
    bus2.br_valid = 1'b1; bus2.branch_type = 3'd5; bus2.target_pc = 32'h2001;
    step();
    bus2.br_valid = 1'b0;
    n_tests++;
    if (outs2() !== 7'b0011111 || bus2.redirect_pc !== 32'h2000) begin
      n_fail++; $display("FAIL flush1_rslv got %b pc=%h exp %b pc=00002000", outs2(), bus2.redirect_pc, 7'b0011111);
    end
    step();
    n_tests++;
    if (outs2() !== 7'b1000000 || bus2.taken_cnt !== 4'h0) begin
      n_fail++; $display("FAIL wrap_post got %b cnt=%h exp %b cnt=0", outs2(), bus2.taken_cnt, 7'b1000000);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.br_valid = 1'b0; bus.branch_type = 3'd0; bus.target_pc = 32'd0;
    bus.alu_done = 1'b0; bus.ALU_neg_flag = 1'b0; bus.ALU_zero_flag = 1'b0;
    bus2.br_valid = 1'b0; bus2.branch_type = 3'd0; bus2.target_pc = 32'd0;
    bus2.alu_done = 1'b0; bus2.ALU_neg_flag = 1'b0; bus2.ALU_zero_flag = 1'b0;

    test_reset();
    test_beq();
    test_bne();
    test_gt_slow_alu();
    test_lt();
    test_jump();
    test_none_type();
    test_reset_in_cmp();
    test_wrap_flush1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
